// File: rtl/dig_spi_responder.sv
// SPI target for the ADC serial-control link: oversamples sen/sck/sdata in the clk domain,
// decodes 16-bit address/data frames into a register file and shifts readback out on sdout.
module dig_spi_responder #(
    parameter int unsigned P_N_REGS      = 32,
    parameter int unsigned P_SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sen,
    input  logic       sck,
    input  logic       sdata,
    output logic       sdout,
    output logic       sdout_oe,
    output logic       reg_wr_strobe,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       frame_err,
    output logic       readout_mode,
    input  logic [7:0] cfg_addr,
    output logic [7:0] cfg_data
);

    localparam int unsigned AW        = (P_N_REGS > 1) ? $clog2(P_N_REGS) : 1;
    localparam int unsigned CW        = 5;
    localparam logic [CW-1:0] CNT_MAX   = CW'(17);
    localparam logic [CW-1:0] CNT_FRAME = CW'(16);
    localparam logic [CW-1:0] CNT_ADDR  = CW'(7);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nx;
    logic [P_SYNC_STAGES-1:0] sen_sync;
    logic [P_SYNC_STAGES-1:0] sck_sync;
    logic [P_SYNC_STAGES-1:0] sdata_sync;
    logic                     sck_prev;
    logic                     sen_s;
    logic                     sck_s;
    logic                     sdata_s;
    logic                     sck_rise;
    logic                     sck_fall;
    logic [15:0]              shift_q;
    logic [CW-1:0]            bit_cnt;
    logic [7:0]               rb_q;
    logic                     rb_armed;
    logic [7:0]               regs [P_N_REGS];
    logic [7:0]               frame_addr;
    logic [7:0]               frame_data;
    logic [7:0]               rb_addr;
    logic                     commit_c;
    logic                     err_c;

    function automatic logic addr_ok(input logic [7:0] a);
        return 9'(a) < 9'(P_N_REGS);
    endfunction

    // Synchronizers; sen and sck reset to their idle-high level so release creates no edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sen_sync   <= '1;
            sck_sync   <= '1;
            sdata_sync <= '0;
            sck_prev   <= 1'b1;
        end else begin
            sen_sync   <= {sen_sync[P_SYNC_STAGES-2:0], sen};
            sck_sync   <= {sck_sync[P_SYNC_STAGES-2:0], sck};
            sdata_sync <= {sdata_sync[P_SYNC_STAGES-2:0], sdata};
            sck_prev   <= sck_s;
        end
    end

    assign sen_s      = sen_sync[P_SYNC_STAGES-1];
    assign sck_s      = sck_sync[P_SYNC_STAGES-1];
    assign sdata_s    = sdata_sync[P_SYNC_STAGES-1];
    assign sck_rise   = sck_s & ~sck_prev;
    assign sck_fall   = ~sck_s & sck_prev;
    assign frame_addr = shift_q[15:8];
    assign frame_data = shift_q[7:0];
    assign rb_addr    = {shift_q[6:0], sdata_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and commit decode
    always_comb begin
        state_nx = state;
        commit_c = 1'b0;
        err_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!sen_s) begin
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sen_s) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
                if (bit_cnt != CNT_FRAME) begin
                    err_c = 1'b1;
                end else if (addr_ok(frame_addr) &&
                             (!readout_mode || (frame_addr == 8'd0))) begin
                    commit_c = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Input shift register and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (state == ST_IDLE && !sen_s) begin
            bit_cnt <= '0;
        end else if (state == ST_SHIFT && !sen_s && sck_rise) begin
            shift_q <= {shift_q[14:0], sdata_s};
            if (bit_cnt != CNT_MAX) begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    // Readback: load after the address byte, then present one bit per sck_fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_q     <= '0;
            rb_armed <= 1'b0;
            sdout    <= 1'b0;
            sdout_oe <= 1'b0;
        end else if (state != ST_SHIFT || sen_s) begin
            rb_armed <= 1'b0;
            sdout    <= 1'b0;
            sdout_oe <= 1'b0;
        end else if (sck_rise && bit_cnt == CNT_ADDR && readout_mode) begin
            rb_q     <= addr_ok(rb_addr) ? regs[rb_addr[AW-1:0]] : 8'd0;
            rb_armed <= 1'b1;
        end else if (sck_fall && rb_armed) begin
            sdout_oe <= 1'b1;
            sdout    <= rb_q[7];
            rb_q     <= {rb_q[6:0], 1'b0};
        end
    end

    // Register file, write report and soft reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(P_N_REGS); i++) begin
                regs[i] <= '0;
            end
            reg_wr_strobe <= 1'b0;
            reg_wr_addr   <= '0;
            reg_wr_data   <= '0;
            frame_err     <= 1'b0;
        end else begin
            reg_wr_strobe <= commit_c;
            frame_err     <= err_c;
            if (commit_c) begin
                reg_wr_addr <= frame_addr;
                reg_wr_data <= frame_data;
                if (frame_addr == 8'd0 && frame_data[1]) begin
                    for (int i = 0; i < int'(P_N_REGS); i++) begin
                        regs[i] <= '0;
                    end
                end else begin
                    regs[frame_addr[AW-1:0]] <= frame_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_data <= '0;
        end else begin
            cfg_data <= addr_ok(cfg_addr) ? regs[cfg_addr[AW-1:0]] : 8'd0;
        end
    end

    assign readout_mode = regs[0][0];

endmodule
